// File: rtl/dense_layer.sv
// Fully-connected classifier stage: one signed MAC per cycle against a weight ROM,
// then floor-shift, bias add and saturation into each logit.
module dense_layer #(
  parameter int    DATA_WIDTH   = 16,
  parameter int    FRAC_BITS    = 7,
  parameter int    CHANNELS     = 8,
  parameter int    IN_SIZE      = 14,
  parameter int    OUT_DIM      = 10,
  parameter string WEIGHTS_FILE = "dense_weights.mem",
  parameter string BIAS_FILE    = "dense_bias.mem"
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] in_feature [0:CHANNELS-1][0:IN_SIZE-1][0:IN_SIZE-1],
  output logic signed [DATA_WIDTH-1:0] out_vec [0:OUT_DIM-1],
  output logic                         busy,
  output logic                         done
);
  localparam int IN_DIM    = CHANNELS * IN_SIZE * IN_SIZE;
  localparam int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(IN_DIM);
  localparam int W_DEPTH   = OUT_DIM * IN_DIM;
  localparam int IDX_W     = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int O_W       = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int WA_W      = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;
  localparam int SW        = ACC_WIDTH + 1;

  localparam logic [IDX_W-1:0]     I_LAST  = IDX_W'(IN_DIM - 1);
  localparam logic [O_W-1:0]       O_LAST  = O_W'(OUT_DIM - 1);
  localparam logic signed [SW-1:0] SAT_MAX = SW'((1 <<< (DATA_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX - SW'(1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_WRITE, S_FINISH} state_t;

  logic signed [DATA_WIDTH-1:0] w_mem [0:W_DEPTH-1];
  logic signed [DATA_WIDTH-1:0] b_mem [0:OUT_DIM-1];

  state_t                         state_q, state_d;
  logic [O_W-1:0]                 o_q, o_d;
  logic [IDX_W-1:0]               i_q, i_d;
  logic [WA_W-1:0]                base_q, base_d;
  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]   out_q [0:OUT_DIM-1];
  logic signed [DATA_WIDTH-1:0]   out_d [0:OUT_DIM-1];
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic [WA_W-1:0]                w_addr;
  logic signed [DATA_WIDTH-1:0]   w_rom_q, b_rom_q;
  logic signed [DATA_WIDTH-1:0]   feat_flat [0:IN_DIM-1];
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [SW-1:0]           sum_s;
  logic signed [DATA_WIDTH-1:0]   sat;

  // Pure rewiring of the 3-D feature map into flatten order c, r, q.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_c
    for (genvar r = 0; r < IN_SIZE; r++) begin : g_r
      for (genvar q = 0; q < IN_SIZE; q++) begin : g_q
        assign feat_flat[c*IN_SIZE*IN_SIZE + r*IN_SIZE + q] = in_feature[c][r][q];
      end
    end
  end

  always_ff @(posedge clk) begin
    w_rom_q <= w_mem[w_addr];
    b_rom_q <= b_mem[o_q];
  end

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    i_d     = i_q;
    base_d  = base_q;
    acc_d   = acc_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = done_q;
    w_addr  = base_q;
    prod    = feat_flat[i_q] * w_rom_q;
    sum_s   = SW'(acc_q >>> FRAC_BITS) + SW'(b_rom_q);
    if (sum_s > SAT_MAX)      sat = SAT_MAX[DATA_WIDTH-1:0];
    else if (sum_s < SAT_MIN) sat = SAT_MIN[DATA_WIDTH-1:0];
    else                      sat = sum_s[DATA_WIDTH-1:0];
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          o_d     = '0;
          i_d     = '0;
          base_d  = '0;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        acc_d   = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_q + ACC_WIDTH'(prod);
        if (i_q == I_LAST) begin
          state_d = S_WRITE;
        end else begin
          i_d    = i_q + IDX_W'(1);
          // Prefetch so the next MAC cycle sees weight i+1 out of the ROM register.
          w_addr = base_q + WA_W'(i_q) + WA_W'(1);
        end
      end
      S_WRITE: begin
        out_d[o_q] = sat;
        if (o_q == O_LAST) begin
          state_d = S_FINISH;
        end else begin
          o_d     = o_q + O_W'(1);
          i_d     = '0;
          base_d  = base_q + WA_W'(IN_DIM);
          state_d = S_LOAD;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      o_q     <= '0;
      i_q     <= '0;
      base_q  <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < OUT_DIM; k++) out_q[k] <= '0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      i_q     <= i_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  assign out_vec = out_q;
  assign busy    = busy_q;
  assign done    = done_q;
endmodule

// File: tb/tb_dense_layer.sv
// Bench for dense_layer: a small 1x2x2 -> 2 instance for directed/handshake/reset cases
// and a default-size instance for one full random inference against a reference model.
module tb_dense_layer;
  localparam int DW  = 16;
  localparam int NS  = 4;
  localparam int OS  = 2;
  localparam int NB  = 1568;
  localparam int OB  = 10;

  logic clk = 1'b0;
  logic rst;
  logic start_s, start_b;
  logic signed [DW-1:0] in_s [0:0][0:1][0:1];
  logic signed [DW-1:0] out_s [0:OS-1];
  logic busy_s, done_s;
  logic signed [DW-1:0] in_b [0:7][0:13][0:13];
  logic signed [DW-1:0] out_b [0:OB-1];
  logic busy_b, done_b;

  always #5 clk = ~clk;

  dense_layer #(.DATA_WIDTH(DW), .FRAC_BITS(7), .CHANNELS(1), .IN_SIZE(2), .OUT_DIM(OS),
                .WEIGHTS_FILE(""), .BIAS_FILE("")) dut_s (
    .clk(clk), .reset(rst), .start(start_s), .in_feature(in_s),
    .out_vec(out_s), .busy(busy_s), .done(done_s));

  dense_layer #(.WEIGHTS_FILE(""), .BIAS_FILE("")) dut_b (
    .clk(clk), .reset(rst), .start(start_b), .in_feature(in_b),
    .out_vec(out_b), .busy(busy_b), .done(done_b));

  int checks = 0;
  int failures = 0;
  logic [OS*DW-1:0] exp_s_q[$];
  logic [OB*DW-1:0] exp_b_q[$];
  logic [OS*DW-1:0] prev_s;

  int feat_s [NS];
  int w_s [OS*NS];
  int b_s [OS];
  int feat_b [NB];
  int w_b [OB*NB];
  int b_b [OB];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int sat16(input longint s);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return int'(s);
  endfunction

  // Reference: dot product in wide integers, floor divide by 2^7, add bias, clamp.
  function automatic logic [OS*DW-1:0] model_s();
    logic [OS*DW-1:0] r;
    int v;
    r = '0;
    for (int o = 0; o < OS; o++) begin
      longint acc = 0;
      for (int i = 0; i < NS; i++) acc += longint'(feat_s[i]) * longint'(w_s[o*NS+i]);
      v = sat16((acc >>> 7) + longint'(b_s[o]));
      r[o*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [OB*DW-1:0] model_b();
    logic [OB*DW-1:0] r;
    int v;
    r = '0;
    for (int o = 0; o < OB; o++) begin
      longint acc = 0;
      for (int i = 0; i < NB; i++) acc += longint'(feat_b[i]) * longint'(w_b[o*NB+i]);
      v = sat16((acc >>> 7) + longint'(b_b[o]));
      r[o*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  task automatic load_small();
    for (int i = 0; i < NS; i++) in_s[0][i/2][i%2] = 16'(feat_s[i]);
    for (int k = 0; k < OS*NS; k++) dut_s.w_mem[k] = 16'(w_s[k]);
    for (int k = 0; k < OS; k++) dut_s.b_mem[k] = 16'(b_s[k]);
  endtask

  task automatic set_small_const(input int f, input int w, input int b0, input int b1);
    for (int i = 0; i < NS; i++) feat_s[i] = f;
    for (int k = 0; k < OS*NS; k++) w_s[k] = w;
    b_s[0] = b0;
    b_s[1] = b1;
    load_small();
  endtask

  task automatic set_small_rand(input int lo, input int hi);
    for (int i = 0; i < NS; i++) feat_s[i] = int'($urandom_range(hi - lo)) + lo;
    for (int k = 0; k < OS*NS; k++) w_s[k] = int'($urandom_range(hi - lo)) + lo;
    for (int k = 0; k < OS; k++) b_s[k] = int'($urandom_range(hi - lo)) + lo;
    load_small();
  endtask

  // One pass on the small DUT; pulse_at>0 injects a stray start at that cycle.
  task automatic run_small(input string tag, input int pulse_at);
    logic [OS*DW-1:0] ex;
    int n;
    ex = model_s();
    exp_s_q.push_back(ex);
    @(negedge clk) start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    check({tag, "_busy_accept"}, longint'(busy_s), 1);
    n = 0;
    while (!done_s && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (pulse_at > 0 && n == pulse_at) start_s = 1'b1;
      if (pulse_at > 0 && n == pulse_at + 1) start_s = 1'b0;
      if (n == 7) begin
        check({tag, "_out0_written"}, longint'(out_s[0]), longint'($signed(ex[0 +: DW])));
        check({tag, "_out1_held"}, longint'(out_s[1]), longint'($signed(prev_s[DW +: DW])));
      end
    end
    start_s = 1'b0;
    check({tag, "_latency"}, n, 13);
    check({tag, "_busy_end"}, longint'(busy_s), 0);
    prev_s = ex;
  endtask

  // Scoreboard monitors: every done pulse pops one expected logit vector.
  always @(negedge clk) begin
    if (done_s) begin
      if (exp_s_q.size() == 0) begin
        check("small_unexpected_done", 1, 0);
      end else begin
        logic [OS*DW-1:0] e;
        e = exp_s_q.pop_front();
        for (int k = 0; k < OS; k++)
          check($sformatf("small_out%0d", k), longint'(out_s[k]), longint'($signed(e[k*DW +: DW])));
      end
    end
  end

  always @(negedge clk) begin
    if (done_b) begin
      if (exp_b_q.size() == 0) begin
        check("big_unexpected_done", 1, 0);
      end else begin
        logic [OB*DW-1:0] e;
        e = exp_b_q.pop_front();
        for (int k = 0; k < OB; k++)
          check($sformatf("big_out%0d", k), longint'(out_b[k]), longint'($signed(e[k*DW +: DW])));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d1, d2, nd;
    logic [OS*DW-1:0] ex;
    rst = 1'b1;
    start_s = 1'b0;
    start_b = 1'b0;
    prev_s = '0;
    set_small_const(0, 0, 0, 0);
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 14; r++)
        for (int q = 0; q < 14; q++) in_b[c][r][q] = '0;
    #22 rst = 1'b0;
    @(negedge clk);
    check("reset_done", longint'(done_s), 0);
    check("reset_busy", longint'(busy_s), 0);
    for (int k = 0; k < OS; k++) check($sformatf("reset_out%0d", k), longint'(out_s[k]), 0);
    check("reset_big_busy", longint'(busy_b), 0);
    for (int k = 0; k < OB; k++) check($sformatf("reset_big_out%0d", k), longint'(out_b[k]), 0);

    // Unity MAC
    set_small_const(128, 128, 0, 64);
    run_small("unity", 0);

    // Flatten ordering
    feat_s = '{128, 256, 384, 512};
    w_s = '{128, 0, 0, 0, 0, 0, 0, 128};
    b_s = '{0, 0};
    load_small();
    run_small("order", 0);

    // Saturation and floor
    set_small_const(32767, 32767, 0, 0);
    run_small("sat_pos", 0);
    set_small_const(-32768, 32767, 0, 0);
    run_small("sat_neg", 0);
    feat_s = '{-1, 0, 0, 0};
    w_s = '{1, 0, 0, 0, 1, 0, 0, 0};
    b_s = '{0, 0};
    load_small();
    run_small("floor", 0);

    // Random passes over narrow and full ranges
    for (int t = 0; t < 6; t++) begin
      if (t % 2 == 0) set_small_rand(-32768, 32767);
      else set_small_rand(-600, 600);
      run_small($sformatf("rand%0d", t), 0);
    end

    // Start held high for 20 cycles: two back-to-back passes
    set_small_rand(-2000, 2000);
    ex = model_s();
    exp_s_q.push_back(ex);
    exp_s_q.push_back(ex);
    @(negedge clk) start_s = 1'b1;
    @(posedge clk); #1;
    n = 0; d1 = 0; d2 = 0; nd = 0;
    while (nd < 2 && n < 45) begin
      @(posedge clk); #1;
      n++;
      if (n == 19) start_s = 1'b0;
      if (done_s) begin
        nd++;
        if (nd == 1) d1 = n;
        else d2 = n;
      end
    end
    start_s = 1'b0;
    check("held_done_count", nd, 2);
    check("held_first_done", d1, 13);
    check("held_second_done", d2, 27);
    prev_s = ex;

    // Stray start pulses mid-pass and during FINISH
    set_small_rand(-3000, 3000);
    run_small("pulse_mid", 5);
    set_small_rand(-3000, 3000);
    run_small("pulse_finish", 12);
    repeat (20) @(posedge clk);
    #1 check("pulse_idle_busy", longint'(busy_s), 0);

    // Asynchronous reset between clock edges at cycle 5 of a pass
    set_small_const(300, 200, 11, -7);
    @(negedge clk) start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("abort_busy_before", longint'(busy_s), 1);
    #3 rst = 1'b1;
    #1;
    check("abort_done", longint'(done_s), 0);
    check("abort_busy", longint'(busy_s), 0);
    for (int k = 0; k < OS; k++) check($sformatf("abort_out%0d", k), longint'(out_s[k]), 0);
    #2 rst = 1'b0;
    prev_s = '0;
    run_small("after_abort", 0);

    // Full-size instance with random features, weights and biases
    for (int i = 0; i < NB; i++) feat_b[i] = int'($urandom_range(512)) - 256;
    for (int k = 0; k < OB*NB; k++) w_b[k] = int'($urandom_range(128)) - 64;
    for (int k = 0; k < OB; k++) b_b[k] = int'($urandom_range(2000)) - 1000;
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 14; r++)
        for (int q = 0; q < 14; q++) in_b[c][r][q] = 16'(feat_b[c*196 + r*14 + q]);
    for (int k = 0; k < OB*NB; k++) dut_b.w_mem[k] = 16'(w_b[k]);
    for (int k = 0; k < OB; k++) dut_b.b_mem[k] = 16'(b_b[k]);
    exp_b_q.push_back(model_b());
    @(negedge clk) start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    n = 0;
    while (!done_b && n < 16000) begin
      @(posedge clk); #1;
      n++;
    end
    check("big_latency", n, 15701);
    repeat (3) @(posedge clk);
    #1 check("big_busy_end", longint'(busy_b), 0);
    check("small_queue_empty", exp_s_q.size(), 0);
    check("big_queue_empty", exp_b_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
